// File: rtl/adder.sv
// adder: WIDTH-bit parallel-prefix (Kogge-Stone) adder with a combinational
// zero-latency sum/carry-out and a registered copy for pipelined consumers.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
);

  // Number of prefix-combining levels needed to span every bit position.
  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] grp_g;
  logic [WIDTH-1:0] grp_p;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  // Per-bit generate and propagate terms.
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
  end

  // Kogge-Stone prefix tree: level k merges each (G,P) group with the group
  // 2^k bits below it; zeros shifted in at the bottom mark groups that already
  // reach bit 0, so after LEVELS levels grp_g[i] is the carry out of bit i.
  always_comb begin
    grp_g = gen;
    grp_p = prop;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      grp_g = grp_g | (grp_p & (grp_g << (1 << lvl)));
      grp_p = grp_p & (grp_p << (1 << lvl));
    end
  end

  // Carry into bit i is the group generate of bits [i-1:0]; no carry-in at bit 0.
  always_comb begin
    carry = {grp_g[WIDTH-2:0], 1'b0};
    sum   = prop ^ carry;
    cout  = grp_g[WIDTH-1];
  end

  // Next values for the registered copy.
  always_comb begin
    sum_d  = sum;
    cout_d = cout;
  end

  // Registered copy with synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_adder.sv
// tb_adder: directed corner cases plus randomized operands checked against a
// plain-arithmetic reference for both the combinational and registered paths.
module tb_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic [W-1:0] sum_q;
  logic         cout_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact (W+1)-bit unsigned sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = (W+1)'(x) + (W+1)'(y);
    return r;
  endfunction

  // Apply operands, check the combinational result without a clock edge, then
  // clock once and check the registered result (cleared when reset is held).
  task automatic apply(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic r);
    logic [W:0] exp;
    a   = x;
    b   = y;
    rst = r;
    exp = ref_add(x, y);
    #1;
    check_eq($sformatf("%s_comb", tag), {cout, sum}, exp);
    @(posedge clk);
    #1;
    check_eq($sformatf("%s_reg", tag), {cout_q, sum_q}, r ? '0 : exp);
    check_eq($sformatf("%s_comb_hold", tag), {cout, sum}, exp);
  endtask

  logic [W-1:0] da [6];
  logic [W-1:0] db [6];

  initial begin
    da = '{32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hAAAA_AAAA};
    db = '{32'h0000_0000, 32'h0000_0007, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h5555_5556};

    // Reset state of the registered path.
    a   = '0;
    b   = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_reg", {cout_q, sum_q}, '0);

    // Spot checks against literal expectations.
    a = 32'h0000_0005; b = 32'h0000_0007; #1;
    check_eq("lit_5p7", {cout, sum}, 33'h0_0000_000C);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; #1;
    check_eq("lit_ffp1", {cout, sum}, 33'h1_0000_0000);
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; #1;
    check_eq("lit_7fp1", {cout, sum}, 33'h0_8000_0000);

    // Directed corner cases, registered path enabled.
    for (int i = 0; i < 6; i++) begin
      apply($sformatf("dir%0d", i), da[i], db[i], 1'b0);
    end

    // Reset mid-operation: registered outputs clear, combinational stays 7.
    apply("mid_run", 32'd3, 32'd4, 1'b0);
    apply("mid_rst", 32'd3, 32'd4, 1'b1);
    check_eq("mid_rst_sum7", {1'b0, sum}, 33'd7);

    // Randomized operands with occasional reset.
    for (int i = 0; i < 1024; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rr;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 1) rb = ~ra;
      rr = ($urandom_range(15) == 0);
      apply($sformatf("rnd%0d", i), ra, rb, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
